// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: per-channel synchronizer and debouncer for asynchronous
// GPIO pad inputs, with registered edge pulses, sticky edge-event flags and
// a single combined interrupt line.
module gpio_in_debounce #(
    parameter int NUM_IN          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] pin_i,
    input  logic [NUM_IN-1:0] evt_clr_i,
    input  logic [NUM_IN-1:0] irq_en_i,
    output logic [NUM_IN-1:0] level_o,
    output logic [NUM_IN-1:0] rise_o,
    output logic [NUM_IN-1:0] fall_o,
    output logic [NUM_IN-1:0] evt_o,
    output logic              irq_o
);

    // The counter only ever reaches DEBOUNCE_CYCLES-1, so it never wraps.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    logic [NUM_IN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IN-1:0] sync_last;

    state_t            state_q [NUM_IN];
    state_t            state_d [NUM_IN];
    logic [CNT_W-1:0]  cnt_q   [NUM_IN];
    logic [CNT_W-1:0]  cnt_d   [NUM_IN];

    logic [NUM_IN-1:0] level_d;
    logic [NUM_IN-1:0] rise_d;
    logic [NUM_IN-1:0] fall_d;
    logic [NUM_IN-1:0] evt_d;
    logic              irq_d;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: pad levels walk through SYNC_STAGES flops before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce FSM next state, counter, level and edge pulses for every channel;
    // the edge that would complete the count toggles the level instead.
    always_comb begin
        level_d = level_o;
        rise_d  = '0;
        fall_d  = '0;
        for (int n = 0; n < NUM_IN; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            unique case (state_q[n])
                STABLE: begin
                    cnt_d[n] = '0;
                    if (sync_last[n] != level_o[n]) begin
                        if (cnt_q[n] == CNT_LAST) begin
                            level_d[n] = ~level_o[n];
                            rise_d[n]  = ~level_o[n];
                            fall_d[n]  = level_o[n];
                        end else begin
                            cnt_d[n]   = CNT_W'(1);
                            state_d[n] = COUNTING;
                        end
                    end
                end
                COUNTING: begin
                    if (sync_last[n] == level_o[n]) begin
                        cnt_d[n]   = '0;
                        state_d[n] = STABLE;
                    end else if (cnt_q[n] == CNT_LAST) begin
                        level_d[n] = ~level_o[n];
                        rise_d[n]  = ~level_o[n];
                        fall_d[n]  = level_o[n];
                        cnt_d[n]   = '0;
                        state_d[n] = STABLE;
                    end else begin
                        cnt_d[n] = cnt_q[n] + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d[n]   = '0;
                    state_d[n] = STABLE;
                end
            endcase
        end
    end

    // Sticky event flags (a new edge beats a simultaneous clear) and the irq term.
    always_comb begin
        evt_d = rise_o | fall_o | (evt_o & ~evt_clr_i);
        irq_d = |(evt_o & irq_en_i);
    end

    // State, counters and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_IN; n++) begin
                state_q[n] <= STABLE;
                cnt_q[n]   <= '0;
            end
            level_o <= '0;
            rise_o  <= '0;
            fall_o  <= '0;
            evt_o   <= '0;
            irq_o   <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_IN; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
            level_o <= level_d;
            rise_o  <= rise_d;
            fall_o  <= fall_d;
            evt_o   <= evt_d;
            irq_o   <= irq_d;
        end
    end

endmodule

// File: doc/gpio_in_debounce.md
GPIO_IN_DEBOUNCE -- requirements
Module: gpio_in_debounce

Interface
REQ-001 Parameter NUM_IN, default 4: number of independent input channels.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles needed to accept a change; must be at least 1.
REQ-004 clk  input  1  single clock for the whole block; all flops on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pin_i  input  NUM_IN  asynchronous pad levels, each taken straight from its input buffer's O.
REQ-007 evt_clr_i  input  NUM_IN  per-channel clear for evt_o; level-sensitive.
REQ-008 irq_en_i  input  NUM_IN  per-channel interrupt enable.
REQ-009 level_o  output  NUM_IN  debounced level.
REQ-010 rise_o  output  NUM_IN  one-cycle pulse when level_o goes 0->1.
REQ-011 fall_o  output  NUM_IN  one-cycle pulse when level_o goes 1->0.
REQ-012 evt_o  output  NUM_IN  sticky edge-event flags.
REQ-013 irq_o  output  1  OR of (evt_o AND irq_en_i).

Function
REQ-014 Each pin_i bit SHALL pass through a chain of SYNC_STAGES flops; only the last stage, sync[n], feeds the debouncer.
REQ-015 Each channel SHALL run a two-state FSM:
- STABLE: sync[n] == level_o[n]; the counter holds 0.
- COUNTING: sync[n] != level_o[n].
REQ-016 The FSM SHALL enter COUNTING on the first edge where sync[n] != level_o[n].
REQ-017 In COUNTING, on each edge where sync[n] != level_o[n] and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-018 In COUNTING, on the edge where sync[n] != level_o[n] and cnt == DEBOUNCE_CYCLES-1:
- level_o[n] SHALL toggle;
- cnt SHALL clear to 0;
- the FSM SHALL return to STABLE.
REQ-019 In COUNTING, on any edge where sync[n] == level_o[n], cnt SHALL clear to 0 and the FSM SHALL return to STABLE; this is glitch rejection, and level_o does not change.
REQ-020 With DEBOUNCE_CYCLES == 1, level_o SHALL toggle on the first edge that sees the difference.
REQ-021 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-022 Latency: a pin change that holds steady SHALL appear on level_o after SYNC_STAGES+DEBOUNCE_CYCLES rising edges, counting the first edge that samples the new value.
REQ-023 rise_o[n] / fall_o[n] SHALL be registered, asserted for exactly one cycle in the same cycle level_o[n] shows the new value, and never both at once.
REQ-024 evt_o[n] SHALL set on rise_o[n] or fall_o[n] and clear on evt_clr_i[n]; when set and clear coincide, set wins.
REQ-025 irq_o SHALL be registered and SHALL follow the evt_o/irq_en_i combination with one cycle of delay.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-027 While rst is high:
- all sync flops, counters, level_o, rise_o, fall_o, evt_o and irq_o SHALL be 0;
- every FSM SHALL be in STABLE.
REQ-028 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted during or on release of reset.
REQ-029 A pin held high through reset release SHALL produce a normal rise_o after the REQ-022 latency, measured from the first edge with rst low.

Verification (defaults NUM_IN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8)
REQ-030 The bench SHALL cover these scenarios:
- Clean press: pin_i[0] 0->1 and held -> level_o[0]=1 on edge 10; rise_o[0] high for that single cycle; evt_o[0]=1 one cycle later; irq_o=1 the cycle after that when irq_en_i[0]=1.
- Glitch: pin_i[1] high for 5 cycles then low -> level_o, rise_o and fall_o stay 0; the counter returns to 0.
- Bounce: pin_i[2] toggles every 3 cycles for 21 cycles, then holds 1 -> exactly one rise_o[2] pulse, 10 edges after the last transition is sampled.
- Set/clear collision: evt_clr_i[0]=1 in the same cycle rise_o[0] sets evt -> evt_o[0] stays 1; evt_clr_i[0]=1 alone next cycle -> evt_o[0]=0; irq_o drops one cycle later.
- Reset mid-count: rst for 2 cycles when cnt=5 with pin_i[3] still high -> all outputs 0, no pulse; rise_o[3] on edge 10 after rst deasserts.
- Simultaneous: pin_i[0] falls and pin_i[1] rises on the same edge -> fall_o[0] and rise_o[1] in the same cycle; evt_o=4'b0011.
